// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell codes, board geometry, move FSM states
// and a helper that picks one cell out of the packed board.
package ttt_pkg;

  localparam int NUM_CELLS = 9;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;
  localparam logic [1:0] TURN_NONE  = 2'b00;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'b00,
    ST_CHECK  = 2'b01,
    ST_COMMIT = 2'b10,
    ST_DONE   = 2'b11
  } move_state_e;

  // A zero one-hot selects nothing and therefore reads as an empty cell.
  function automatic logic [1:0] cell_of(input logic [17:0] board,
                                         input logic [8:0]  onehot);
    logic [1:0] c;
    c = CELL_EMPTY;
    for (int k = 0; k < NUM_CELLS; k++) begin
      c = c | (board[2*k +: 2] & {2{onehot[k]}});
    end
    return c;
  endfunction

endpackage

// File: rtl/ttt_pos_decode.sv
// Cell-number decoder: maps a 1..9 cell index to a one-hot over the nine cells
// (bit k = cell k+1) and flags anything outside that range.
module ttt_pos_decode
  import ttt_pkg::*;
(
  input  logic [3:0] pos_i,
  output logic [8:0] onehot_o,
  output logic       pos_valid_o
);

  // One-hot lookup; out-of-range positions decode to nothing.
  always_comb begin
    onehot_o = 9'h000;
    case (pos_i)
      4'd1:    onehot_o = 9'h001;
      4'd2:    onehot_o = 9'h002;
      4'd3:    onehot_o = 9'h004;
      4'd4:    onehot_o = 9'h008;
      4'd5:    onehot_o = 9'h010;
      4'd6:    onehot_o = 9'h020;
      4'd7:    onehot_o = 9'h040;
      4'd8:    onehot_o = 9'h080;
      4'd9:    onehot_o = 9'h100;
      default: onehot_o = 9'h000;
    endcase
  end

  assign pos_valid_o = |onehot_o;

endmodule

// File: rtl/ttt_move_ctrl.sv
// Turn controller in front of the position store: validates a requested cell,
// issues a one-cycle write enable for the player to move, and ends the game.
module ttt_move_ctrl
  import ttt_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play_req_i,
  input  logic [3:0]  play_pos_i,
  input  logic [17:0] board_i,
  input  logic        win_i,
  output logic [8:0]  Play1_en_o,
  output logic [8:0]  Play2_en_o,
  output logic        ill_o,
  output logic [1:0]  turn_o,
  output logic [3:0]  move_cnt_o,
  output logic        game_over_o,
  output logic        draw_o
);

  move_state_e state_q, state_d;
  logic        play_req_q;
  logic        req_edge;
  logic [3:0]  pos_q, pos_d;
  logic [8:0]  pos_onehot;
  logic        pos_valid;
  logic        move_illegal;
  logic [1:0]  turn_q, turn_d;
  logic [3:0]  cnt_q, cnt_d, cnt_inc;
  logic        game_over_q, game_over_d;
  logic        draw_q, draw_d;

  ttt_pos_decode u_pos_decode (
    .pos_i       (pos_q),
    .onehot_o    (pos_onehot),
    .pos_valid_o (pos_valid)
  );

  // The edge register follows the level in every state, so a held button never retriggers.
  assign req_edge     = play_req_i & ~play_req_q;
  assign move_illegal = ~pos_valid | (cell_of(board_i, pos_onehot) != CELL_EMPTY);
  assign cnt_inc      = (cnt_q == 4'd9) ? 4'd9 : cnt_q + 4'd1;

  // State, latched position and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      play_req_q  <= 1'b0;
      pos_q       <= 4'd0;
      turn_q      <= FIRST_PLAYER;
      cnt_q       <= 4'd0;
      game_over_q <= 1'b0;
      draw_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      play_req_q  <= play_req_i;
      pos_q       <= pos_d;
      turn_q      <= turn_d;
      cnt_q       <= cnt_d;
      game_over_q <= game_over_d;
      draw_q      <= draw_d;
    end
  end

  // Next-state logic; a win seen while waiting outranks a simultaneous request.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    case (state_q)
      ST_WAIT: begin
        if (win_i) begin
          state_d = ST_DONE;
        end else if (req_edge) begin
          state_d = ST_CHECK;
          pos_d   = play_pos_i;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_CHECK: begin
        if (move_illegal) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (cnt_inc == 4'd9) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_WAIT;
    endcase
  end

  // Registered status: turn and count advance as COMMIT retires; draw is re-evaluated every cycle in DONE.
  always_comb begin
    cnt_d = (state_q == ST_COMMIT) ? cnt_inc : cnt_q;
    if (state_d == ST_DONE) begin
      turn_d = TURN_NONE;
    end else if (state_q == ST_COMMIT) begin
      turn_d = (turn_q == CELL_P1) ? CELL_P2 : CELL_P1;
    end else begin
      turn_d = turn_q;
    end
    game_over_d = (state_d == ST_DONE);
    draw_d      = (state_d == ST_DONE) && (cnt_d == 4'd9) && !win_i;
  end

  // Store strobes decode straight from state so an asynchronous reset drops them at once.
  always_comb begin
    ill_o      = 1'b0;
    Play1_en_o = 9'h000;
    Play2_en_o = 9'h000;
    case (state_q)
      ST_CHECK: ill_o = move_illegal;
      ST_COMMIT: begin
        if (turn_q == CELL_P1) begin
          Play1_en_o = pos_onehot;
        end else if (turn_q == CELL_P2) begin
          Play2_en_o = pos_onehot;
        end else begin
          Play1_en_o = 9'h000;
          Play2_en_o = 9'h000;
        end
      end
      default: begin
        ill_o      = 1'b0;
        Play1_en_o = 9'h000;
        Play2_en_o = 9'h000;
      end
    endcase
  end

  assign turn_o      = turn_q;
  assign move_cnt_o  = cnt_q;
  assign game_over_o = game_over_q;
  assign draw_o      = draw_q;

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Directed bench for ttt_move_ctrl: the bench plays the position store itself,
// updating its board copy whenever a legal move is committed.
module tb_ttt_move_ctrl;

  logic        clk;
  logic        rst_n;
  logic        play_req;
  logic [3:0]  play_pos;
  logic [17:0] board;
  logic        win;
  logic [8:0]  Play1_en;
  logic [8:0]  Play2_en;
  logic        ill;
  logic [1:0]  turn;
  logic [3:0]  move_cnt;
  logic        game_over;
  logic        draw;

  int n_cmp;
  int n_fail;
  int en_pulses;
  int ill_pulses;
  int e0;
  int i0;

  ttt_move_ctrl #(.FIRST_PLAYER(2'b01)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .play_req_i  (play_req),
    .play_pos_i  (play_pos),
    .board_i     (board),
    .win_i       (win),
    .Play1_en_o  (Play1_en),
    .Play2_en_o  (Play2_en),
    .ill_o       (ill),
    .turn_o      (turn),
    .move_cnt_o  (move_cnt),
    .game_over_o (game_over),
    .draw_o      (draw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally strobe cycles mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((Play1_en != 9'h000) || (Play2_en != 9'h000)) en_pulses++;
      if (ill) ill_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full legal move: edge, CHECK (no ill), COMMIT (enable for who), then back to WAIT.
  task automatic do_move(input logic [3:0] pos, input logic [1:0] who);
    logic [8:0] oh;
    int         p;
    p  = int'(pos) - 1;
    oh = 9'h001 << p;
    play_req = 1'b1;
    play_pos = pos;
    tick();
    chk("mv_ill", ill, 1'b0);
    play_req = 1'b0;
    tick();
    chk("mv_p1en", Play1_en, (who == 2'b01) ? oh : 9'h000);
    chk("mv_p2en", Play2_en, (who == 2'b10) ? oh : 9'h000);
    board[2*p +: 2] = who;
    tick();
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    en_pulses  = 0;
    ill_pulses = 0;
    rst_n      = 1'b0;
    play_req   = 1'b0;
    play_pos   = 4'd0;
    board      = 18'h0;
    win        = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_turn", turn, 2'b01);
    chk("rst_cnt", move_cnt, 4'd0);
    chk("rst_p1en", Play1_en, 9'h000);
    chk("rst_p2en", Play2_en, 9'h000);
    chk("rst_ill", ill, 1'b0);
    chk("rst_over", game_over, 1'b0);
    chk("rst_draw", draw, 1'b0);

    // Test 1: P1 takes the centre; timing of enable and turn/count update.
    play_req = 1'b1;
    play_pos = 4'd5;
    tick();
    chk("t1_check_ill", ill, 1'b0);
    chk("t1_check_p1en", Play1_en, 9'h000);
    play_req = 1'b0;
    tick();
    chk("t1_p1en", Play1_en, 9'h010);
    chk("t1_p2en", Play2_en, 9'h000);
    chk("t1_turn_hold", turn, 2'b01);
    board[9:8] = 2'b01;
    tick();
    chk("t1_p1en_off", Play1_en, 9'h000);
    chk("t1_turn", turn, 2'b10);
    chk("t1_cnt", move_cnt, 4'd1);

    // Test 2: P2 tries the occupied centre.
    play_req = 1'b1;
    play_pos = 4'd5;
    tick();
    chk("t2_ill", ill, 1'b1);
    chk("t2_p2en", Play2_en, 9'h000);
    play_req = 1'b0;
    tick();
    chk("t2_ill_off", ill, 1'b0);
    chk("t2_turn", turn, 2'b10);
    chk("t2_cnt", move_cnt, 4'd1);

    // Test 3: out-of-range positions 0 and 12.
    play_req = 1'b1;
    play_pos = 4'd0;
    tick();
    chk("t3_ill_pos0", ill, 1'b1);
    play_req = 1'b0;
    tick();
    play_req = 1'b1;
    play_pos = 4'd12;
    tick();
    chk("t3_ill_pos12", ill, 1'b1);
    play_req = 1'b0;
    tick();
    chk("t3_en_pulses", en_pulses, 1);
    chk("t3_ill_pulses", ill_pulses, 3);
    chk("t3_cnt", move_cnt, 4'd1);

    // Test 4a: button held for 20 cycles commits exactly once.
    play_req = 1'b1;
    play_pos = 4'd1;
    tick();
    tick();
    chk("t4_p2en", Play2_en, 9'h001);
    board[1:0] = 2'b10;
    repeat (18) tick();
    chk("t4_en_pulses", en_pulses, 2);
    chk("t4_turn", turn, 2'b01);
    chk("t4_cnt", move_cnt, 4'd2);
    play_req = 1'b0;
    tick();

    // Test 4b: a fresh edge arriving during COMMIT is dropped.
    play_req = 1'b1;
    play_pos = 4'd2;
    tick();
    play_req = 1'b0;
    tick();
    chk("t4b_p1en", Play1_en, 9'h002);
    board[3:2] = 2'b01;
    play_req = 1'b1;
    tick();
    repeat (4) tick();
    chk("t4b_en_pulses", en_pulses, 3);
    chk("t4b_ill_pulses", ill_pulses, 3);
    chk("t4b_cnt", move_cnt, 4'd3);
    chk("t4b_turn", turn, 2'b10);
    play_req = 1'b0;
    tick();

    // Test 5: fill the board with no win.
    do_move(4'd3, 2'b10);
    do_move(4'd4, 2'b01);
    do_move(4'd6, 2'b10);
    do_move(4'd7, 2'b01);
    do_move(4'd8, 2'b10);
    chk("t5_cnt8", move_cnt, 4'd8);
    do_move(4'd9, 2'b01);
    chk("t5_cnt", move_cnt, 4'd9);
    chk("t5_turn", turn, 2'b00);
    chk("t5_over", game_over, 1'b1);
    chk("t5_draw", draw, 1'b1);
    e0 = en_pulses;
    i0 = ill_pulses;
    play_req = 1'b1;
    play_pos = 4'd1;
    tick();
    chk("t5_10th_ill", ill, 1'b0);
    play_req = 1'b0;
    repeat (3) tick();
    chk("t5_10th_en", en_pulses - e0, 0);
    chk("t5_10th_illcnt", ill_pulses - i0, 0);
    chk("t5_cnt_sat", move_cnt, 4'd9);
    win = 1'b1;
    tick();
    chk("t5_late_win_draw", draw, 1'b0);
    chk("t5_late_win_over", game_over, 1'b1);

    // Test 6: win after move 5, then reset mid-COMMIT.
    rst_n = 1'b0;
    win   = 1'b0;
    board = 18'h0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_rst_cnt", move_cnt, 4'd0);
    do_move(4'd1, 2'b01);
    do_move(4'd2, 2'b10);
    do_move(4'd3, 2'b01);
    do_move(4'd4, 2'b10);
    do_move(4'd5, 2'b01);
    chk("t6_cnt5", move_cnt, 4'd5);
    win = 1'b1;
    tick();
    chk("t6_over", game_over, 1'b1);
    chk("t6_turn", turn, 2'b00);
    chk("t6_draw", draw, 1'b0);
    e0 = en_pulses;
    i0 = ill_pulses;
    play_req = 1'b1;
    play_pos = 4'd6;
    tick();
    play_req = 1'b0;
    repeat (3) tick();
    chk("t6_ignored_en", en_pulses - e0, 0);
    chk("t6_ignored_ill", ill_pulses - i0, 0);
    chk("t6_cnt_hold", move_cnt, 4'd5);

    rst_n = 1'b0;
    win   = 1'b0;
    board = 18'h0;
    tick();
    rst_n = 1'b1;
    tick();
    play_req = 1'b1;
    play_pos = 4'd7;
    tick();
    play_req = 1'b0;
    tick();
    chk("t6_commit_p1en", Play1_en, 9'h040);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_p1en", Play1_en, 9'h000);
    chk("t6_async_p2en", Play2_en, 9'h000);
    #3;
    rst_n = 1'b1;
    tick();
    chk("t6_turn_first", turn, 2'b01);
    chk("t6_cnt_zero", move_cnt, 4'd0);
    chk("t6_over_clr", game_over, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
